// File: rtl/cp0_except_pkg.sv
// Shared CP0 register numbers, exception codes, ExcCode values and field positions.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package cp0_except_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_EBASE    = 5'd15;

  // Codes presented to the pipeline controller on excepttype_o
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] EXC_BP   = 32'h0000_000f;
  localparam logic [31:0] EXC_ADEF = 32'h0000_0010;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0011;
  localparam logic [31:0] EXC_ADES = 32'h0000_0012;

  // Cause.ExcCode values
  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  // Raw exception flag positions from the memory stage
  localparam int RAW_SYS  = 8;
  localparam int RAW_RI   = 9;
  localparam int RAW_OV   = 11;
  localparam int RAW_ERET = 12;
  localparam int RAW_BP   = 13;
  localparam int RAW_ADEF = 14;
  localparam int RAW_ADEL = 15;
  localparam int RAW_ADES = 16;

  // Status / Cause field positions
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  // Software-writable bits per register
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  // Map an excepttype_o code to the ExcCode stored in Cause
  function automatic logic [4:0] exccode_of(input logic [31:0] exc);
    logic [4:0] code;
    case (exc)
      EXC_ADEF, EXC_ADEL: code = CODE_ADEL;
      EXC_ADES:           code = CODE_ADES;
      EXC_SYS:            code = CODE_SYS;
      EXC_BP:             code = CODE_BP;
      EXC_RI:             code = CODE_RI;
      EXC_OV:             code = CODE_OV;
      default:            code = CODE_INT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the sticky timer interrupt.
// Latency: writes and the interrupt flag update on the next rising edge.
// Backpressure: none; writes are always accepted.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  // Free-running counter, compare register and interrupt flag; a write wins over the increment,
  // and a Compare write clears the flag even if the match happens in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_except.sv
// CP0 register file plus exception arbiter for the memory stage; optional timer under CP0_TIMER_EN.
// Latency: excepttype/epc/ebase/rdata combinational; register updates at the next rising edge.
// Backpressure: none; the controller flushes on any nonzero code so commits never collide.
module cp0_except
  import cp0_except_pkg::*;
#(
  parameter logic [31:0] RESET_EBASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] excepttype_raw_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, cause_q, epc_q, badvaddr_q, ebase_q;
  logic [31:0] status_eff, cause_eff, epc_eff, ebase_eff;
  logic [31:0] count_rd, compare_rd;
  logic        timer_int;
  logic        wr_status, wr_cause, wr_epc, wr_ebase;
  logic        commit, eret;
  logic [7:0]  pending;
  logic        unused_raw;

  assign wr_status = we_i && (waddr_i == REG_STATUS);
  assign wr_cause  = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc    = we_i && (waddr_i == REG_EPC);
  assign wr_ebase  = we_i && (waddr_i == REG_EBASE);

  // Same-cycle mtc0 merged into the registered values so eret/interrupt see the write immediately
  assign status_eff = wr_status ? ((status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK)) : status_q;
  assign cause_eff  = wr_cause  ? ((cause_q  & ~CAUSE_WMASK)  | (wdata_i & CAUSE_WMASK))  : cause_q;
  assign epc_eff    = wr_epc    ? wdata_i : epc_q;
  assign ebase_eff  = wr_ebase  ? ((ebase_q & ~EBASE_WMASK) | (wdata_i & EBASE_WMASK)) : ebase_q;

`ifdef CP0_TIMER_EN
  logic        wr_count, wr_compare;
  logic [31:0] count_q, compare_q;

  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (wdata_i),
    .count      (count_q),
    .compare    (compare_q),
    .timer_int  (timer_int)
  );

  assign count_rd   = wr_count   ? wdata_i : count_q;
  assign compare_rd = wr_compare ? wdata_i : compare_q;
`else
  assign count_rd   = '0;
  assign compare_rd = '0;
  assign timer_int  = 1'b0;
`endif

  // Flag bits that carry no exception meaning
  assign unused_raw = ^{excepttype_raw_i[31:17], excepttype_raw_i[10], excepttype_raw_i[7:0]};

  assign pending = cause_eff[15:8] & status_eff[15:8];

  // Fixed-priority pick of at most one exception; suppressed for bubbles and during reset
  always_comb begin
    excepttype_o = '0;
    if (rst && mem_valid_i) begin
      if (status_eff[STATUS_IE] && !status_eff[STATUS_EXL] && (pending != 8'd0))
        excepttype_o = EXC_INT;
      else if (excepttype_raw_i[RAW_ADEF]) excepttype_o = EXC_ADEF;
      else if (excepttype_raw_i[RAW_RI])   excepttype_o = EXC_RI;
      else if (excepttype_raw_i[RAW_BP])   excepttype_o = EXC_BP;
      else if (excepttype_raw_i[RAW_SYS])  excepttype_o = EXC_SYS;
      else if (excepttype_raw_i[RAW_OV])   excepttype_o = EXC_OV;
      else if (excepttype_raw_i[RAW_ADEL]) excepttype_o = EXC_ADEL;
      else if (excepttype_raw_i[RAW_ADES]) excepttype_o = EXC_ADES;
      else if (excepttype_raw_i[RAW_ERET]) excepttype_o = EXC_ERET;
    end
  end

  assign eret   = (excepttype_o == EXC_ERET);
  assign commit = (excepttype_o != 32'd0) && !eret;

  // Register state: mtc0 writes, interrupt sampling, and exception/eret commit (commit wins)
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q   <= 32'h1000_0000;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      ebase_q    <= RESET_EBASE;
    end else begin
      status_q <= status_eff;
      if (commit)    status_q[STATUS_EXL] <= 1'b1;
      else if (eret) status_q[STATUS_EXL] <= 1'b0;

      cause_q[15:10] <= {int_i[5] | timer_int, int_i[4:0]};

      if (commit) begin
        cause_q[6:2] <= exccode_of(excepttype_o);
        if (!status_eff[STATUS_EXL]) begin
          cause_q[CAUSE_BD] <= in_delayslot_i;
          epc_q             <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        end
        if (excepttype_o == EXC_ADEF)
          badvaddr_q <= pc_i;
        else if ((excepttype_o == EXC_ADEL) || (excepttype_o == EXC_ADES))
          badvaddr_q <= mem_addr_i;
      end else begin
        if (wr_cause) cause_q[9:8] <= wdata_i[9:8];
        if (wr_epc)   epc_q        <= wdata_i;
      end

      if (wr_ebase) ebase_q <= ebase_eff;
    end
  end

  // mfc0 read port with same-cycle write bypass; unmapped numbers read zero
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_rd;
      REG_COMPARE:  rdata_o = compare_rd;
      REG_STATUS:   rdata_o = status_eff;
      REG_CAUSE:    rdata_o = cause_eff;
      REG_EPC:      rdata_o = epc_eff;
      REG_EBASE:    rdata_o = ebase_eff;
      default:      rdata_o = '0;
    endcase
  end

  assign epc_o       = epc_eff;
  assign ebase_o     = ebase_eff;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_except.sv
// Directed-vector bench for cp0_except with hand-computed expectations.
// Latency: checks combinational outputs before the edge and registered state after it.
// Backpressure: n/a.
module tb_cp0_except;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        mem_valid_i;
  logic [31:0] excepttype_raw_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic [31:0] excepttype_o, epc_o, ebase_o, status_o, cause_o;
  logic        timer_int_o;

  int errors = 0;
  int checks = 0;

  cp0_except dut (
    .clk              (clk),
    .rst              (rst),
    .we_i             (we_i),
    .waddr_i          (waddr_i),
    .wdata_i          (wdata_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .int_i            (int_i),
    .mem_valid_i      (mem_valid_i),
    .excepttype_raw_i (excepttype_raw_i),
    .pc_i             (pc_i),
    .in_delayslot_i   (in_delayslot_i),
    .mem_addr_i       (mem_addr_i),
    .excepttype_o     (excepttype_o),
    .epc_o            (epc_o),
    .ebase_o          (ebase_o),
    .status_o         (status_o),
    .cause_o          (cause_o),
    .timer_int_o      (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we_i             = 1'b0;
    waddr_i          = 5'd0;
    wdata_i          = 32'd0;
    raddr_i          = 5'd0;
    int_i            = 6'd0;
    mem_valid_i      = 1'b0;
    excepttype_raw_i = 32'd0;
    pc_i             = 32'd0;
    in_delayslot_i   = 1'b0;
    mem_addr_i       = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    raddr_i = a;
    #1;
    v = rdata_o;
  endtask

  logic [31:0] v;

  initial begin
    idle();
    rst = 1'b0;
    tick();
    tick();

    // Reset state; excepttype forced low even with a pending syscall
    mem_valid_i = 1'b1;
    excepttype_raw_i = 32'h0000_0100;
    #1;
    check("rst_exc", excepttype_o, 32'h0);
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_ebase_o", ebase_o, 32'h8000_0000);
    check("rst_timer", 32'(timer_int_o), 32'h0);
    rd(5'd14, v); check("rst_epc", v, 32'h0);
    idle();
    rst = 1'b1;
    tick();

    // Syscall
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0000_0100; pc_i = 32'h8000_0100;
    #1;
    check("sys_code", excepttype_o, 32'h08);
    tick(); idle();
    rd(5'd14, v); check("sys_epc", v, 32'h8000_0100);
    check("sys_exccode", 32'(cause_o[6:2]), 32'd8);
    check("sys_status", status_o, 32'h1000_0002);

    // Clear EXL through mtc0 Status
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0;
    tick(); idle();
    check("clr_exl", status_o, 32'h1000_0000);

    // Overflow in a delay slot
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0000_0800; in_delayslot_i = 1'b1; pc_i = 32'h8000_0204;
    #1;
    check("ov_code", excepttype_o, 32'h0c);
    tick(); idle();
    rd(5'd14, v); check("ov_epc", v, 32'h8000_0200);
    check("ov_bd", 32'(cause_o[31]), 32'd1);
    check("ov_exccode", 32'(cause_o[6:2]), 32'd12);

    // Interrupt beats syscall, with Status written the same cycle (EXL was 1)
    int_i = 6'b000001;
    tick();
    check("int_ip", 32'(cause_o[10]), 32'd1);
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_0401;
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0000_0100; pc_i = 32'h8000_0300;
    #1;
    check("int_code", excepttype_o, 32'h01);
    tick(); idle();
    check("int_status", status_o, 32'h1000_0403);
    check("int_exccode", 32'(cause_o[6:2]), 32'd0);
    check("int_bd", 32'(cause_o[31]), 32'd0);
    rd(5'd14, v); check("int_epc", v, 32'h8000_0300);

    // Instruction address error outranks syscall and store error; EXL=1 holds EPC
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0001_4100; pc_i = 32'h8000_0500;
    #1;
    check("adef_code", excepttype_o, 32'h10);
    tick(); idle();
    rd(5'd8, v); check("adef_badv", v, 32'h8000_0500);
    check("adef_exccode", 32'(cause_o[6:2]), 32'd4);
    rd(5'd14, v); check("adef_epc_hold", v, 32'h8000_0300);

    // Store address error
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0001_0000; mem_addr_i = 32'h0000_0003; pc_i = 32'h8000_0600;
    #1;
    check("ades_code", excepttype_o, 32'h12);
    tick(); idle();
    rd(5'd8, v); check("ades_badv", v, 32'h0000_0003);
    check("ades_exccode", 32'(cause_o[6:2]), 32'd5);

    // BadVAddr ignores writes
    we_i = 1'b1; waddr_i = 5'd8; wdata_i = 32'hFFFF_FFFF;
    rd(5'd8, v); check("badv_ro_byp", v, 32'h0000_0003);
    tick(); idle();
    rd(5'd8, v); check("badv_ro", v, 32'h0000_0003);

`ifdef CP0_TIMER_EN
    // Timer: Compare=5 then Count=0; flag rises on the 6th edge after the Count write
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd5;
    rd(5'd11, v); check("cmp_byp", v, 32'd5);
    tick(); idle();
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'd0;
    tick(); idle();
    rd(5'd9, v); check("cnt_wr", v, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("timer_early", 32'(timer_int_o), 32'd0);
    end
    tick();
    check("timer_set", 32'(timer_int_o), 32'd1);
    tick();
    check("timer_sticky", 32'(timer_int_o), 32'd1);
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd0;
    tick(); idle();
    check("timer_clr", 32'(timer_int_o), 32'd0);
    tick();
`else
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h0000_1234;
    rd(5'd9, v); check("cnt_off_byp", v, 32'd0);
    tick(); idle();
    rd(5'd9, v); check("cnt_off", v, 32'd0);
    check("timer_off", 32'(timer_int_o), 32'd0);
`endif

    // eret with EXL=1
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0000_1000;
    #1;
    check("eret_code", excepttype_o, 32'h0e);
    check("eret_epc", epc_o, 32'h8000_0300);
    tick(); idle();
    check("eret_status", status_o, 32'h1000_0401);

    // Bubble suppresses everything; valid with no flags gives zero
    excepttype_raw_i = 32'h0000_0100;
    #1;
    check("bubble", excepttype_o, 32'h0);
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0;
    #1;
    check("no_flags", excepttype_o, 32'h0);
    idle();

    // eret sees a same-cycle EPC write
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h8000_0700;
    mem_valid_i = 1'b1; excepttype_raw_i = 32'h0000_1000;
    #1;
    check("eret_byp_code", excepttype_o, 32'h0e);
    check("eret_byp_epc", epc_o, 32'h8000_0700);
    tick(); idle();

    // EBase write mask
    we_i = 1'b1; waddr_i = 5'd15; wdata_i = 32'hFFFF_FFFF;
    #1;
    check("ebase_byp", ebase_o, 32'hBFFF_F000);
    tick(); idle();
    rd(5'd15, v); check("ebase_rd", v, 32'hBFFF_F000);

    // Cause write mask and unmapped read
    we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hFFFF_FFFF;
    rd(5'd13, v); check("cause_ip_sw", 32'(v[9:8]), 32'd3);
    tick(); idle();
    check("cause_bd_ro", 32'(cause_o[31]), 32'd0);
    rd(5'd3, v); check("unmapped", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_except.md
# cp0_except

Coprocessor-0 register file and exception arbiter for the MIPS pipeline. Each cycle it takes the raw exception flags, PC, delay-slot flag and data address of the instruction in the memory stage, and picks at most one exception. It drives `excepttype_o`, `epc_o` and `ebase_o` to the pipeline controller, which uses them the same cycle to raise flush and select the new PC. It also keeps Status, Cause, EPC, BadVAddr, Count, Compare and EBase, and updates them on the clock edge that commits an exception or `eret`.

## Interface
- `RESET_EBASE`, default 32'h8000_0000, reset value of EBase.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-low.
- `we_i` in 1: CP0 write enable from writeback (mtc0).
- `waddr_i` in 5: write register number.
- `wdata_i` in 32: write data.
- `raddr_i` in 5: read register number (mfc0).
- `rdata_o` out 32: read data, combinational, bypassed from the same-cycle write.
- `int_i` in 6: external hardware interrupt lines (IP7..IP2).
- `mem_valid_i` in 1: memory-stage instruction is real; low means a bubble.
- `excepttype_raw_i` in 32: flag bits from the memory stage:
  - [8] syscall, [9] reserved instruction, [11] overflow, [12] eret, [13] break
  - [14] instruction address error, [15] load address error, [16] store address error
- `pc_i` in 32: memory-stage instruction address.
- `in_delayslot_i` in 1: instruction is in a branch delay slot.
- `mem_addr_i` in 32: data address for load/store address errors.
- `excepttype_o` out 32: encoded exception code; zero means none.
- `epc_o` out 32: effective EPC; bypassed, so `eret` uses a same-cycle mtc0 EPC.
- `ebase_o` out 32: effective EBase, bypassed the same way.
- `status_o` out 32: registered Status.
- `cause_o` out 32: registered Cause.
- `timer_int_o` out 1: registered timer interrupt.

## Operation
- **Register map and write masks.** Writes are masked; unmapped registers read 0.
  - BadVAddr (8): read-only.
  - Count (9): all 32 bits writable.
  - Compare (11): all 32 bits writable; a write clears `timer_int_o`.
  - Status (12): writable IM[15:8], EXL[1], IE[0].
  - Cause (13): writable IP[9:8] only.
  - EPC (14): all 32 bits writable.
  - EBase (15): writable [29:12]; other bits fixed from `RESET_EBASE`.
- **Cause.IP[15:10].** Sampled from `int_i` every cycle. IP[15] = `int_i[5] | timer_int_o`.
- **Effective Status/Cause.** The arbiter uses register values with the same-cycle `we_i` write merged in.
- **Arbitration.** Only when `mem_valid_i`=1. Priority, highest first, with the `excepttype_o` code:
  - interrupt 0x01: IE=1, EXL=0 and (IP & IM) != 0;
  - instruction address error 0x10;
  - reserved instruction 0x0a;
  - break 0x0f;
  - syscall 0x08;
  - overflow 0x0c;
  - load address error 0x11;
  - store address error 0x12;
  - eret 0x0e.
- **Commit on the next clk edge, non-eret.**
  - EXL←1.
  - If EXL was 0: EPC←`pc_i` (`pc_i`-4 if in delay slot) and Cause.BD←`in_delayslot_i`.
  - If EXL was already 1, EPC and BD are held.
  - Cause.ExcCode: Int 0, AdEL 4 (codes 0x10 and 0x11), AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - BadVAddr←`pc_i` for code 0x10, `mem_addr_i` for 0x11 and 0x12.
- **Commit, eret.** EXL←0; EPC and Cause unchanged.
- **Write vs exception, same edge.** A committing exception overrides the same-cycle mtc0 write to EPC, Cause and BadVAddr. The EXL update overrides any written EXL bit; other written Status bits still land.
- **Count.**
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - A write to Count takes precedence over the increment.
  - When Count == Compare and Compare != 0, `timer_int_o` is set the next cycle. It stays set until Compare is written.

## Timing
- `excepttype_o`, `epc_o`, `ebase_o` and `rdata_o` are combinational, with zero-cycle latency to the controller.
- All register updates take effect at the following rising edge.
- **Reset**, sampled at the rising edge while `rst`=0:
  - Status 0x1000_0000; Cause, EPC, BadVAddr, Count, Compare 0; EBase `RESET_EBASE`; `timer_int_o` 0.
  - `excepttype_o` is forced to 0 while `rst`=0.
- Reset wins over any same-cycle write or commit.
- Flush follows in the same cycle as a nonzero code. The next memory-stage instruction is a bubble, so back-to-back commits cannot occur.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare logic and `timer_int_o` are present as described.
- Not defined:
  - Count and Compare read 0 and ignore writes.
  - `timer_int_o` is tied to 0.
  - IP[15] = `int_i[5]` only.

## Structure
- Shared defines header holds:
  - register numbers 8/9/11/12/13/14/15;
  - the `excepttype_o` codes;
  - the ExcCode values;
  - the Status/Cause field bit positions.
- One sub-module, `cp0_timer`: Count/Compare/`timer_int_o`, instantiated only under `CP0_TIMER_EN`.

## Test plan
- **Reset.** Hold `rst`=0 two cycles → Status 0x1000_0000, EBase 0x8000_0000, `excepttype_o` 0.
- **Syscall.** `mem_valid_i`=1, raw bit 8, `pc_i` 0x8000_0100 → `excepttype_o` 0x08 same cycle; next cycle EPC 0x8000_0100, ExcCode 8, EXL 1.
- **Delay-slot overflow.** Raw bit 11, `in_delayslot_i`=1, `pc_i` 0x8000_0204 → EPC 0x8000_0200, Cause.BD 1.
- **Interrupt priority.** mtc0 Status 0x0000_0401 with `int_i`[0]=1 and raw bit 8 set, same cycle → `excepttype_o` 0x01 (write bypassed), ExcCode 0.
- **Store address error.** Raw bit 16, `mem_addr_i` 0x0000_0003 → code 0x12, BadVAddr 0x0000_0003, ExcCode 5.
- **Timer.** Write Compare 5, Count 0 → `timer_int_o` 1 six cycles later; writing Compare drops it; `eret` with EXL=1 → code 0x0e, `epc_o` = EPC, EXL 0 next cycle.
